// File: rtl/aes_pkg.sv
// Shared types, tables and byte-level helpers for the iterative AES-128 decrypt datapath.
// Bytes are numbered 0..15 from [127:120] downward, column-major as in FIPS-197.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Indexed by the round counter, which counts 9 down to 0 while the schedule is unwound
  localparam logic [7:0] RCON_DEC [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Row r rotates right by r positions
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t res;
    logic [7:0] a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      res[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      res[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      res[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      res[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_dec_core_inv_round_tf.sv
// One combinational inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module inv_round_tf
  import aes_pkg::*;
(
  input  aes_state_t state,
  input  aes_state_t round_key,
  input  logic       last_round,
  output aes_state_t next_state
);

  aes_state_t shifted;
  aes_state_t substituted;
  aes_state_t keyed;

  assign shifted = inv_shift_rows(state);

  always_comb begin
    substituted = '0;
    for (int i = 0; i < 16; i++) begin
      substituted[8*i +: 8] = inv_sbox(shifted[8*i +: 8]);
    end
  end

  assign keyed      = substituted ^ round_key;
  assign next_state = last_round ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_dec_core.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, with the key
// schedule unwound on the fly from the last round key back to the cipher key.
module aes_dec_core
  import aes_pkg::*;
#(
  parameter bit EN_KEY_O = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] ct_i,
  input  logic [127:0] rk10_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] pt_o,
  output logic [127:0] key_o,
  output logic         busy_o
);

  state_e     state_q, state_d;
  aes_state_t st_q, rk_q, pt_q;
  aes_state_t st_next, rk_next;
  logic [3:0] rnd_q;
  logic       last_round;
  logic       load, step, finish;

  // Recovers the previous round key from the current one
  function automatic aes_state_t inv_ks(input aes_state_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  assign last_round = (rnd_q == 4'd0);
  assign rk_next    = inv_ks(rk_q, RCON_DEC[rnd_q]);

  inv_round_tf u_round (
    .state      (st_q),
    .round_key  (rk_next),
    .last_round (last_round),
    .next_state (st_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Handshake outputs decode straight from the state register so a reset drops them at once
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_round) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // pt_q only ever takes the fully decrypted state, never an intermediate round
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q  <= '0;
      rk_q  <= '0;
      pt_q  <= '0;
      rnd_q <= 4'd9;
    end else begin
      if (load) begin
        st_q  <= ct_i ^ rk10_i;
        rk_q  <= rk10_i;
        rnd_q <= 4'd9;
      end else if (step) begin
        st_q <= st_next;
        rk_q <= rk_next;
        if (!finish) rnd_q <= rnd_q - 4'd1;
      end
      if (finish) pt_q <= st_next;
    end
  end

  assign pt_o = pt_q;

  generate
    if (EN_KEY_O) begin : g_key
      aes_state_t key_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     key_q <= '0;
        else if (finish) key_q <= rk_next;
      end
      assign key_o = key_q;
    end else begin : g_no_key
      assign key_o = '0;
    end
  endgenerate

endmodule

// File: tb/tb_aes_dec_core.sv
// Scoreboard bench for aes_dec_core: a forward AES-128 model built from GF(2^8) arithmetic
// produces ciphertexts and last round keys; a monitor checks every delivered result.
module tb_aes_dec_core;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ct, rk10, pt, key;
  logic         nk_in_valid, nk_in_ready, nk_out_valid, nk_out_ready, nk_busy;
  logic [127:0] nk_ct, nk_rk10, nk_pt, nk_key;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    int           acc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] sb_ref [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dec_core dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .ct_i        (ct),
    .rk10_i      (rk10),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .pt_o        (pt),
    .key_o       (key),
    .busy_o      (busy)
  );

  aes_dec_core #(.EN_KEY_O(1'b0)) dut_nk (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (nk_in_valid),
    .in_ready_o  (nk_in_ready),
    .ct_i        (nk_ct),
    .rk10_i      (nk_rk10),
    .out_valid_o (nk_out_valid),
    .out_ready_i (nk_out_ready),
    .pt_o        (nk_pt),
    .key_o       (nk_key),
    .busy_o      (nk_busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic expectTrue(input string name, input logic cond);
    tests++;
    if (cond !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s: condition false, expected true", name);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic buildSbox();
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sb_ref[x] = b;
    end
  endtask

  function automatic void aes_encrypt(input logic [127:0] pt_in, input logic [127:0] key_in,
                                      output logic [127:0] ct_out, output logic [127:0] rk10_out);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rkr;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key_in[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]} ^ {rc, 24'h000000};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt_in[127-8*i -: 8] ^ key_in[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      rkr = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) u[i] = sb_ref[s[i]];
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) s[row+4*c] = u[row+4*((c+row)%4)];
      end
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkr[127-8*i -: 8];
    end
    ct_out = '0;
    for (int i = 0; i < 16; i++) ct_out[127-8*i -: 8] = s[i];
    rk10_out = {w[40], w[41], w[42], w[43]};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  task automatic applyStimulus(input logic [127:0] c, input logic [127:0] k,
                               input logic [127:0] exp_pt, input logic [127:0] exp_key, output int acc);
    exp_t e;
    int   n;
    logic taken;
    in_valid = 1'b1;
    ct       = c;
    rk10     = k;
    n        = 0;
    taken    = 1'b0;
    acc      = -1;
    while (!taken && n < 100) begin
      @(negedge clk);
      if (in_ready) taken = 1'b1;
      n++;
    end
    expectTrue("accept_timeout", taken);
    if (taken) begin
      acc   = cyc + 1;
      e.pt  = exp_pt;
      e.key = exp_key;
      e.acc = acc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    expectTrue("drain_timeout", sb_q.size() == 0);
    sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic runMonitor();
    exp_t e;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !prev_valid) begin
        if (sb_q.size() == 0) expectTrue("spurious_valid", 1'b0);
        else checkOutput("latency", 128'(cyc - sb_q[0].acc + 1), 128'd11);
      end
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          expectTrue("spurious_result", 1'b0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("pt", pt, e.pt);
          checkOutput("key", key, e.key);
        end
      end
      prev_valid = rst_n && out_valid;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int           acc, prev_acc, n;
    logic [127:0] rp, rk, rc_t, rr;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    ct           = '0;
    rk10         = '0;
    nk_in_valid  = 1'b0;
    nk_out_ready = 1'b1;
    nk_ct        = '0;
    nk_rk10      = '0;
    buildSbox();
    fork
      runMonitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_pt", pt, 128'd0);
    checkOutput("rst_key", key, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-answer vectors
    applyStimulus(C1_CT, C1_RK, C1_PT, C1_KEY, acc);
    waitDrain();
    applyStimulus(B_CT, B_RK, B_PT, B_KEY, acc);
    waitDrain();

    // Result held under back-pressure while a new block is offered
    out_ready = 1'b0;
    applyStimulus(B_CT, B_RK, B_PT, B_KEY, acc);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    expectTrue("bp_valid_timeout", out_valid);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    ct       = C1_CT;
    rk10     = C1_RK;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp_pt", pt, B_PT);
      checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
      checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", 128'(in_ready), 128'd1);
    checkOutput("release_busy", 128'(busy), 128'd0);
    waitDrain();

    // Abort in the middle of a decryption
    applyStimulus(C1_CT, C1_RK, C1_PT, C1_KEY, acc);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
    checkOutput("abort_busy", 128'(busy), 128'd0);
    checkOutput("abort_in_ready", 128'(in_ready), 128'd1);
    checkOutput("abort_pt", pt, 128'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(C1_CT, C1_RK, C1_PT, C1_KEY, acc);
    waitDrain();

    // Back-to-back random blocks
    prev_acc = -1;
    for (int k = 0; k < 100; k++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      aes_encrypt(rp, rk, rc_t, rr);
      applyStimulus(rc_t, rr, rp, rk, acc);
      if (k > 0) checkOutput("interval", 128'(acc - prev_acc), 128'd12);
      prev_acc = acc;
    end
    waitDrain();

    // Build without the key output
    nk_in_valid = 1'b1;
    nk_ct       = C1_CT;
    nk_rk10     = C1_RK;
    @(posedge clk);
    #1;
    nk_in_valid = 1'b0;
    n = 0;
    while (!nk_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    expectTrue("nk_valid_timeout", nk_out_valid);
    checkOutput("nk_pt", nk_pt, C1_PT);
    checkOutput("nk_key", nk_key, 128'd0);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
